mux_select_arbiter: RTL and testbench

Round-robin arbiter that shares the team's 2:1 select mux (inputs `a`/`b`, control `select`, output `y`; `select`=0 passes `a`, 1 passes `b`) between two requesters. It owns `select`, issues one-hot grants, and enforces a bounded hold time under contention. It drives the mux output `y` plus a `y_valid` qualifier to the downstream consumer.

---
 rtl/mux_select_arbiter_if.sv | 29 ++
 rtl/mux_select_arbiter.sv | 125 ++++++++++++
 tb/tb_mux_select_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/mux_select_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mux_select_arbiter_if : request/grant and mux data bundle for the arbiter
// Revision 1.0
// ---------------------------------------------------------------------------
interface mux_select_arbiter_if #(
  parameter int WIDTH = 1
);
  logic             req_a;
  logic             req_b;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             gnt_a;
  logic             gnt_b;
  logic             select;
  logic [WIDTH-1:0] y;
  logic             y_valid;

  modport master (
    output req_a, req_b, a, b,
    input  gnt_a, gnt_b, select, y, y_valid
  );

  modport slave (
    input  req_a, req_b, a, b,
    output gnt_a, gnt_b, select, y, y_valid
  );
endinterface
`default_nettype wire

// File: rtl/mux_select_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mux_select_arbiter : two-requester round-robin owner of a 2:1 mux select,
// with bounded hold under contention. MUX_ARB_OUT_REG_EN registers y/y_valid.
// Revision 1.0
// ---------------------------------------------------------------------------
module mux_select_arbiter #(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 4
) (
  input  wire logic           clk,
  input  wire logic           rst,
  mux_select_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_t;

  localparam logic       SERVED_A   = 1'b0;
  localparam logic       SERVED_B   = 1'b1;
  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);

  state_t           state;
  state_t           state_next;
  logic [7:0]       hold_cnt;
  logic             last_served;
  logic             select_q;
  logic             enter_a;
  logic             enter_b;
  logic             at_limit;
  logic             grant_any;
  logic [WIDTH-1:0] y_mux;

  assign at_limit = (hold_cnt == HOLD_LIMIT);

  always_comb begin
    state_next = state;
    enter_a    = 1'b0;
    enter_b    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.req_a && bus.req_b)
          state_next = (last_served == SERVED_B) ? GNT_A : GNT_B;
        else if (bus.req_a)
          state_next = GNT_A;
        else if (bus.req_b)
          state_next = GNT_B;
      end
      GNT_A: begin
        if (bus.req_a) begin
          if (bus.req_b && at_limit)
            state_next = GNT_B;
        end else begin
          // Owner gone: hand straight over rather than bubbling through IDLE.
          state_next = bus.req_b ? GNT_B : IDLE;
        end
      end
      GNT_B: begin
        if (bus.req_b) begin
          if (bus.req_a && at_limit)
            state_next = GNT_A;
        end else begin
          state_next = bus.req_a ? GNT_A : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    enter_a = (state_next == GNT_A) && (state != GNT_A);
    enter_b = (state_next == GNT_B) && (state != GNT_B);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      hold_cnt    <= 8'd0;
      last_served <= SERVED_B;
      select_q    <= 1'b0;
    end else begin
      state <= state_next;
      if (enter_a) begin
        hold_cnt    <= 8'd0;
        last_served <= SERVED_A;
        select_q    <= 1'b0;
      end else if (enter_b) begin
        hold_cnt    <= 8'd0;
        last_served <= SERVED_B;
        select_q    <= 1'b1;
      end else if ((state != IDLE) && !at_limit) begin
        hold_cnt <= hold_cnt + 8'd1;
      end
    end
  end

  assign bus.gnt_a  = (state == GNT_A);
  assign bus.gnt_b  = (state == GNT_B);
  assign bus.select = select_q;
  assign grant_any  = (state == GNT_A) || (state == GNT_B);
  assign y_mux      = select_q ? bus.b : bus.a;

`ifdef MUX_ARB_OUT_REG_EN
  logic [WIDTH-1:0] y_q;
  logic             y_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else begin
      y_q       <= y_mux;
      y_valid_q <= grant_any;
    end
  end

  assign bus.y       = y_q;
  assign bus.y_valid = y_valid_q;
`else
  assign bus.y       = y_mux;
  assign bus.y_valid = grant_any;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux_select_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mux_select_arbiter : directed bench for MAX_HOLD=4 and MAX_HOLD=1 builds.
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_mux_select_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  mux_select_arbiter_if #(.WIDTH(1)) bus4 ();
  mux_select_arbiter_if #(.WIDTH(1)) bus1 ();

  mux_select_arbiter #(.WIDTH(1), .MAX_HOLD(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  mux_select_arbiter #(.WIDTH(1), .MAX_HOLD(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  typedef struct {
    int   which;
    logic ga;
    logic gb;
    logic sel;
    logic yv;
    logic y;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   stepno   = 0;
  logic prev_sel = 1'b0;
  logic prev_gnt = 1'b0;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s step=%0d observed=%b expected=%b", tag, stepno, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus to both DUTs, queue the expectation for the
  // DUT under test, then compare just after the edge.
  task automatic step(input logic r, input logic ra, input logic rb,
                      input logic da, input logic db, input int which,
                      input logic ega, input logic egb, input logic esel);
    exp_t e;
    exp_t got;
    rst        = r;
    bus4.req_a = ra; bus4.req_b = rb; bus4.a = da; bus4.b = db;
    bus1.req_a = ra; bus1.req_b = rb; bus1.a = da; bus1.b = db;
    e.which = which;
    e.ga    = ega;
    e.gb    = egb;
    e.sel   = esel;
`ifdef MUX_ARB_OUT_REG_EN
    if (r) begin
      e.y  = 1'b0;
      e.yv = 1'b0;
    end else begin
      e.y  = prev_sel ? db : da;
      e.yv = prev_gnt;
    end
`else
    e.y  = esel ? db : da;
    e.yv = ega | egb;
`endif
    prev_sel = esel;
    prev_gnt = ega | egb;
    sb.push_back(e);
    @(posedge clk);
    #1;
    stepno++;
    got = sb.pop_front();
    if (got.which == 1) begin
      chk("gnt_a",   bus1.gnt_a,   got.ga);
      chk("gnt_b",   bus1.gnt_b,   got.gb);
      chk("select",  bus1.select,  got.sel);
      chk("y_valid", bus1.y_valid, got.yv);
      chk("y",       bus1.y[0],    got.y);
    end else begin
      chk("gnt_a",   bus4.gnt_a,   got.ga);
      chk("gnt_b",   bus4.gnt_b,   got.gb);
      chk("select",  bus4.select,  got.sel);
      chk("y_valid", bus4.y_valid, got.yv);
      chk("y",       bus4.y[0],    got.y);
    end
  endtask

  initial begin
    logic ea;
    logic ra;
    logic rb;

    // Reset held with both requests high.
    for (int i = 0; i < 3; i++) step(1, 1, 1, 1, 0, 0, 0, 0, 0);
    // First grant after release goes to A.
    step(0, 1, 1, 1, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0, 0);

    // Single requester B for 10 cycles, no hold limit.
    for (int i = 0; i < 10; i++) step(0, 0, 1, 0, 1, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 0, 0, 0, 1);

    // Contention with MAX_HOLD=4: A x4, B x4, ...
    for (int i = 0; i < 20; i++) begin
      ea = (((i / 4) % 2) == 0);
      step(0, 1, 1, 1, 0, 0, ea, !ea, !ea);
    end
    step(0, 0, 0, 1, 0, 0, 0, 0, 0);

    // Early release: A owns, B joins, A drops -> same-edge handover.
    step(0, 1, 0, 1, 0, 0, 1, 0, 0);
    step(0, 1, 1, 1, 0, 0, 1, 0, 0);
    step(0, 0, 1, 1, 0, 0, 0, 1, 1);
    step(0, 0, 1, 0, 1, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 0, 0, 0, 1);

    // Reset during GNT_B with hold_cnt=2.
    step(0, 0, 1, 0, 1, 0, 0, 1, 1);
    step(0, 0, 1, 0, 1, 0, 0, 1, 1);
    step(0, 0, 1, 0, 1, 0, 0, 1, 1);
    step(1, 1, 1, 1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 0, 0, 1, 0, 0);
    step(0, 1, 1, 1, 0, 0, 1, 0, 0);

    // MAX_HOLD=1: strict alternation, y tracks a then b.
    step(1, 0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      ea = ((i % 2) == 0);
      ra = 1'($urandom_range(0, 1));
      rb = 1'($urandom_range(0, 1));
      step(0, 1, 1, ra, rb, 1, ea, !ea, !ea);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
